mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one fixed-latency unified memory between instruction fetch (I-port,
//   read-only) and data access (D-port, LW/SW). Sits between the fetch/memory
//   stages and the memory model. Serves one transaction at a time; D-port has
//   priority in IDLE; alternates after each completion so neither port starves.
// PARAMETERS
//   ADDR_W   16  address width (word addresses)
//   DATA_W   16  data width
//   MEM_LAT  4   memory access cycles per transaction, legal range >= 1
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       synchronous reset, active-high
//   i_req      in   1       fetch request; held with i_addr until i_done
//   i_addr     in   ADDR_W  fetch address
//   i_done     out  1       one-cycle pulse: fetch complete, i_rdata valid
//   i_rdata    out  DATA_W  fetched word, registered, held until next i_done
//   d_req      in   1       data request; held with d_addr/d_we/d_wdata until d_done
//   d_we       in   1       1 = write (SW), 0 = read (LW)
//   d_addr     in   ADDR_W  data address
//   d_wdata    in   DATA_W  store data
//   d_done     out  1       one-cycle pulse: data op complete, d_rdata valid on reads
//   d_rdata    out  DATA_W  loaded word, registered, held until next d_done
//   mem_en     out  1       memory access active
//   mem_wr     out  1       memory write enable, qualified by mem_en
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid in last access cycle
//   busy       out  1       1 in any state except IDLE
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0; all outputs 0 (incl. i_rdata, d_rdata, latched regs).
//   States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
//   IDLE: d_req -> BUSY_D; else i_req -> BUSY_I; else stay. Both high -> D wins.
//   Grant edge latches addr (and we/wdata for D) into internal regs; mem_* are
//     driven only from latched regs, never directly from ports.
//   BUSY_x: mem_en=1, mem_wr=latched we (0 for I), cnt increments each cycle.
//     At cnt==MEM_LAT-1: capture mem_rdata into x_rdata (D reads only; D writes
//     leave d_rdata unchanged), cnt<=0, go DONE_x.
//   DONE_x: x_done=1 for exactly this cycle, mem_en=0. Served port's req is
//     ignored this cycle. Other port's req high -> BUSY_other (latch on this
//     edge); else IDLE.
//   Latency: req sampled in IDLE at cycle 0 -> mem_en cycles 1..MEM_LAT ->
//     done in cycle MEM_LAT+1. Back-to-back alternating service: one done per
//     MEM_LAT+1 cycles.
//   Requester dropping req mid-transaction: transaction still completes and
//     done still pulses; requester ignores it. Input changes during BUSY have
//     no effect.
//   i_done and d_done are never high in the same cycle.
//   Reset mid-transaction: returns to IDLE next edge, no done pulse, mem_en=0;
//     content at the interrupted write address is undefined.
//   cnt width $clog2(MEM_LAT+1); no wrap beyond MEM_LAT-1.
// TESTING
//   1 i_req=1, i_addr=0x0010, mem holds 0xA5A5 -> mem_en cycles 1-4,
//     i_done=1 in cycle 5, i_rdata=0xA5A5, busy low from cycle 6 if no req.
//   2 i_req and d_req both rise in cycle 0 (d_we=0, d_addr=0x0200) -> D served
//     first (d_done cycle 5), I granted from DONE_D, i_done in cycle 10.
//   3 d_req, d_we=1, d_addr=0x0300, d_wdata=0x1234 -> mem_wr=1 cycles 1-4,
//     d_done cycle 5, d_rdata unchanged; later read of 0x0300 returns 0x1234.
//   4 d_req held high continuously, i_req high -> grants alternate D,I,D,I;
//     i_done every 10 cycles, no starvation.
//   5 rst pulsed in cycle 2 of BUSY_D write -> state IDLE, mem_en=0, no d_done,
//     all outputs 0 after reset edge.
//   6 MEM_LAT=1: i_req in cycle 0 -> mem_en cycle 1 only, i_done cycle 2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, response and memory bus bundle for mem_arbiter
//
// Signals (directions as seen by the arbiter through modport slave):
//   i_req, i_addr                 in   fetch request and address
//   i_done, i_rdata               out  fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata  in   data request, write flag, address, store data
//   d_done, d_rdata               out  data completion pulse and loaded word
//   mem_en, mem_wr                out  memory access active / write enable
//   mem_addr, mem_wdata           out  memory address / write data
//   mem_rdata                     in   memory read data
//   busy                          out  arbiter not idle
// modport master is the requester/memory side view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a fixed-latency unified memory
//
// Ports:
//   clk   in  clock, all state on rising edge
//   rst   in  synchronous reset, active-high
//   bus   mem_arbiter_if.slave: I-port (read-only), D-port (read/write),
//         memory bus and busy flag
// One transaction at a time. D wins a tie from IDLE; on completion the other
// port is served next if it is waiting, so neither port can starve.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              grant_i, grant_d;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  assign last = (cnt == CNT_W'(MEM_LAT - 1));

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req)      grant_d = 1'b1;
        else if (bus.i_req) grant_i = 1'b1;
      end
      BUSY_I: if (last) next_state = DONE_I;
      BUSY_D: if (last) next_state = DONE_D;
      // The port just served is ignored here; only the other one can be granted.
      DONE_I: begin
        if (bus.d_req) grant_d = 1'b1;
        else           next_state = IDLE;
      end
      DONE_D: begin
        if (bus.i_req) grant_i = 1'b1;
        else           next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (grant_d)      next_state = BUSY_D;
    else if (grant_i) next_state = BUSY_I;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= next_state;
      // Request fields are captured only on the grant edge, so requesters
      // changing them mid-transaction cannot disturb the memory bus.
      if (grant_d) begin
        lat_addr  <= bus.d_addr;
        lat_we    <= bus.d_we;
        lat_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        lat_addr  <= bus.i_addr;
        lat_we    <= 1'b0;
        lat_wdata <= '0;
      end
      if (state == BUSY_I || state == BUSY_D) begin
        if (last) begin
          cnt <= '0;
          if (state == BUSY_I)  i_rdata_q <= bus.mem_rdata;
          else if (!lat_we)     d_rdata_q <= bus.mem_rdata;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.mem_en    = (state == BUSY_I) || (state == BUSY_D);
  assign bus.mem_wr    = (state == BUSY_D) && lat_we;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.i_done    = (state == DONE_I);
  assign bus.d_done    = (state == DONE_D);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : ((a ^ 16'h3C3C) + 16'h0101);
  endfunction

  // memory model for the LAT=4 instance
  logic [15:0] mem [0:65535];
  bit filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int a = 0; a < 65536; a++) mem[a] = init_val(16'(a));
      filled = 1'b1;
    end else if (bus.mem_en && bus.mem_wr) begin
      mem[bus.mem_addr] = bus.mem_wdata;
    end
  end
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus1.mem_rdata = init_val(bus1.mem_addr);

  // reference: memory contents as the sequence of completed writes
  logic [15:0] ref_w [logic [15:0]];
  logic [15:0] exp_i = '0;
  logic [15:0] exp_d = '0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_w.exists(a)) return ref_w[a];
    return init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues up to one request per port in the same cycle (cycle 0) from IDLE
  // and checks every cycle against the timeline: D first if present, the
  // other port granted straight out of DONE, each access LAT cycles long.
  task automatic run_txn(input bit ui, input bit ud, input bit we,
                         input logic [15:0] ia, input logic [15:0] da,
                         input logic [15:0] wd);
    int d_done_c, i_done_c, ib, last;
    bit in_d, in_i;
    @(posedge clk); #1;
    bus.i_req = ui; bus.i_addr = ia;
    bus.d_req = ud; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
    d_done_c = ud ? LAT + 1 : -1;
    ib       = ud ? LAT + 2 : 1;
    i_done_c = ui ? ib + LAT : -1;
    last     = ui ? i_done_c : d_done_c;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      in_d = ud && c >= 1 && c <= LAT;
      in_i = ui && c >= ib && c < ib + LAT;
      check("mem_en", bus.mem_en, in_d || in_i);
      check("mem_wr", bus.mem_wr, in_d && we);
      if (in_d) check("mem_addr_d", bus.mem_addr, da);
      if (in_i) check("mem_addr_i", bus.mem_addr, ia);
      if (in_d && we) check("mem_wdata", bus.mem_wdata, wd);
      check("i_done", bus.i_done, c == i_done_c);
      check("d_done", bus.d_done, c == d_done_c);
      check("busy", bus.busy, c >= 1 && c <= last);
      if (c == d_done_c) begin
        if (we) ref_w[da] = wd;
        else    exp_d = ref_rd(da);
        check("d_rdata", bus.d_rdata, exp_d);
        bus.d_req = 1'b0;
      end
      if (c == i_done_c) begin
        exp_i = ref_rd(ia);
        check("i_rdata", bus.i_rdata, exp_i);
        bus.i_req = 1'b0;
      end
      // requesters wander while being served; the bus must not follow
      if (in_d && c < LAT) begin
        bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom); bus.d_we = 1'($urandom);
      end
      if (in_i && c < ib + LAT - 1) bus.i_addr = 16'($urandom);
    end
  endtask

  initial begin
    logic [1:0] kind;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst1_busy", bus1.busy, 0);
    rst = 1'b0;

    // fetch of 0x0010
    run_txn(1, 0, 0, 16'h0010, 16'h0000, 16'h0000);
    check("t1_i_rdata", bus.i_rdata, 16'hA5A5);
    // simultaneous requests, D first
    run_txn(1, 1, 0, 16'h0011, 16'h0200, 16'h0000);
    // store then load back
    run_txn(0, 1, 1, 16'h0000, 16'h0300, 16'h1234);
    run_txn(0, 1, 0, 16'h0000, 16'h0300, 16'h0000);
    check("t3_readback", bus.d_rdata, 16'h1234);

    for (int n = 0; n < 30; n++) begin
      kind = 2'($urandom_range(1, 3));
      run_txn(kind[0], kind[1], 1'($urandom_range(0, 1)),
              16'h0100 + 16'($urandom_range(0, 15)),
              16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom));
    end

    // both ports held: completions alternate D, I, D, I every LAT+1 cycles
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0105;
    bus.i_req = 1; bus.i_addr = 16'h0106;
    for (int c = 0; c <= 4 * (LAT + 1); c++) begin
      @(negedge clk);
      check("alt_d_done", bus.d_done, c > 0 && c % (LAT + 1) == 0 && (c / (LAT + 1)) % 2 == 1);
      check("alt_i_done", bus.i_done, c > 0 && c % (LAT + 1) == 0 && (c / (LAT + 1)) % 2 == 0);
      if (bus.d_done) check("alt_d_rdata", bus.d_rdata, ref_rd(16'h0105));
      if (bus.i_done) check("alt_i_rdata", bus.i_rdata, ref_rd(16'h0106));
      if (c == 4 * (LAT + 1)) begin bus.d_req = 0; bus.i_req = 0; end
    end
    @(negedge clk);
    check("alt_idle", bus.busy, 0);

    // reset in the middle of a write
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0400; bus.d_wdata = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("t5_pre_mem_wr", bus.mem_wr, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", bus.busy, 0);
    check("t5_mem_en", bus.mem_en, 0);
    check("t5_mem_wr", bus.mem_wr, 0);
    check("t5_mem_addr", bus.mem_addr, 0);
    check("t5_mem_wdata", bus.mem_wdata, 0);
    check("t5_d_done", bus.d_done, 0);
    check("t5_i_rdata", bus.i_rdata, 0);
    check("t5_d_rdata", bus.d_rdata, 0);
    rst = 1'b0; bus.d_req = 0;
    exp_i = '0; exp_d = '0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      check("t5_no_done", bus.d_done, 0);
      check("t5_stay_idle", bus.busy, 0);
    end

    // MEM_LAT = 1 instance
    @(posedge clk); #1;
    bus1.i_req = 1; bus1.i_addr = 16'h0020;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      check("t6_mem_en", bus1.mem_en, c == 1);
      check("t6_i_done", bus1.i_done, c == 2);
      check("t6_busy", bus1.busy, c == 1 || c == 2);
      if (c == 2) begin
        check("t6_i_rdata", bus1.i_rdata, init_val(16'h0020));
        bus1.i_req = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
